// File: rtl/xoro_reset_seq_pkg.sv
// Shared types for the xoro reset sequencer: FSM state encoding, reset-cause codes
// and the counter-width helper used by every counter in the block.
package xoro_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_RELEASE = 2'd2
  } state_e;

  localparam logic [1:0] CAUSE_POR  = 2'b00;
  localparam logic [1:0] CAUSE_SW   = 2'b01;
  localparam logic [1:0] CAUSE_BTN  = 2'b10;
  localparam logic [1:0] CAUSE_BOTH = 2'b11;

  // A counter whose terminal value is 0 still needs one bit to exist.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/xoro_reset_seq_if.sv
// Request/status bundle between the SoC-level reset controller logic and the sequencer.
interface xoro_reset_seq_if #(
  parameter int N_OUT = 3
);

  logic             btn_in;
  logic             sw_req;
  logic [N_OUT-1:0] rst_n_out;
  logic             busy;
  logic             done;
  logic [1:0]       cause;

  modport master (
    output btn_in, sw_req,
    input  rst_n_out, busy, done, cause
  );

  modport slave (
    input  btn_in, sw_req,
    output rst_n_out, busy, done, cause
  );

endinterface

// File: rtl/xoro_reset_seq_debounce.sv
// Push-button conditioner: 2-FF synchroniser followed by a stability counter.
// Produces the debounced pressed level and a one-cycle pulse on each new press.
module xoro_debounce
  import xoro_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic level,
  output logic press
);

  localparam int          CW       = cnt_width(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic        IDLE_RAW = BTN_ACTIVE_LOW;

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          sync_pressed;

  assign sync_pressed = sync2_q ^ IDLE_RAW;

  // The counter only runs while the synchronised input disagrees with the held level.
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
    cnt_d   = '0;
    level_d = level_q;
    press_d = 1'b0;
    if (sync_pressed != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync_pressed;
        press_d = sync_pressed;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= IDLE_RAW;
      sync2_q <= IDLE_RAW;
      level_q <= 1'b0;
      press_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/xoro_reset_seq.sv
// xoro SoC reset sequencer: merges power-on, button and software requests into a
// programmable-length reset and releases N_OUT active-low resets in staged order.
module xoro_reset_seq
  import xoro_pkg::*;
#(
  parameter int N_OUT           = 3,
  parameter int HOLD_CYCLES     = 16,
  parameter int STAGE_GAP       = 4,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  xoro_reset_seq_if.slave bus
);

  localparam int HW = cnt_width(HOLD_CYCLES - 1);
  localparam int GW = cnt_width(STAGE_GAP - 1);
  localparam int SW = cnt_width(N_OUT - 1);

  localparam logic [HW-1:0] HOLD_LAST  = HW'(HOLD_CYCLES - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(STAGE_GAP - 1);
  localparam logic [SW-1:0] STAGE_LAST = SW'(N_OUT - 1);

  state_e           state_q, state_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [SW-1:0]    stage_q, stage_d;
  logic [N_OUT-1:0] rst_n_q, rst_n_d;
  logic             done_q, done_d;
  logic [1:0]       cause_q, cause_d;

  logic btn_level;
  logic btn_press;
  logic req;

  xoro_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_debounce (
    .clk    (clk),
    .reset  (reset),
    .btn_in (bus.btn_in),
    .level  (btn_level),
    .press  (btn_press)
  );

  assign req = bus.sw_req | btn_press;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_ASSERT;
      hold_q  <= '0;
      gap_q   <= '0;
      stage_q <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
      cause_q <= CAUSE_POR;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      stage_q <= stage_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
      cause_q <= cause_d;
    end
  end

  // A held button pins the sequence at the start of ASSERT until it is released.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    stage_d = stage_q;
    if (req || btn_level) begin
      state_d = ST_ASSERT;
      hold_d  = '0;
      gap_d   = '0;
      stage_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (hold_q == HOLD_LAST) begin
            gap_d = '0;
            if (N_OUT == 1) begin
              state_d = ST_IDLE;
            end else begin
              state_d = ST_RELEASE;
              stage_d = SW'(1);
            end
          end else begin
            hold_d = hold_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            gap_d = '0;
            if (stage_q == STAGE_LAST) begin
              state_d = ST_IDLE;
            end else begin
              stage_d = stage_q + 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rst_n_d = rst_n_q;
    done_d  = 1'b0;
    cause_d = cause_q;
    if (req) begin
      if (btn_press) begin
        cause_d = bus.sw_req ? CAUSE_BOTH : CAUSE_BTN;
      end else begin
        cause_d = CAUSE_SW;
      end
    end
    if (req || btn_level) begin
      rst_n_d = '0;
    end else begin
      case (state_q)
        ST_ASSERT: begin
          if (hold_q == HOLD_LAST) begin
            rst_n_d[0] = 1'b1;
            done_d     = (N_OUT == 1);
          end
        end
        ST_RELEASE: begin
          if (gap_q == GAP_LAST) begin
            rst_n_d[stage_q] = 1'b1;
            done_d           = (stage_q == STAGE_LAST);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.rst_n_out = rst_n_q;
  assign bus.busy      = ~&rst_n_q;
  assign bus.done      = done_q;
  assign bus.cause     = cause_q;

endmodule
